// File: rtl/histogram_stream.sv
// histogram_stream: streaming histogrammer with a mix of wide and narrow saturating bins.
// Samples are binned by a bit field of data_in while IDLE. A dump, started by dump_req or by
// hitting a saturated bin with auto_dump_en set, streams every bin out in index order over a
// ready/valid port and clears each bin as its beat is accepted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   data_in, in_valid     sample input; in_ready is high exactly while IDLE
//   dump_req              request a full dump (pulse)
//   auto_dump_en          1: saturating sample triggers a dump; 0: sample discarded, sat_flag set
//   out_data, out_bin     bin count (zero-extended) and its index
//   out_valid, out_ready  output handshake; out_last marks bin NUM_BINS-1
//   sat_flag              sticky discard indicator, cleared when a dump completes
module histogram_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_LSB   = 0,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned WIDE_BINS = 10,
  parameter int unsigned WIDE_W    = 8,
  parameter int unsigned NARROW_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dump_req,
  input  logic              auto_dump_en,
  output logic [WIDE_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sat_flag
);

  localparam int unsigned NUM_BINS = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LastBin = IDX_W'(NUM_BINS - 1);

  typedef enum logic {StIdle, StDump} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic              pend_q, pend_d;
  logic              sat_q, sat_d;
  logic [WIDE_W-1:0] rd [NUM_BINS];
  logic [NUM_BINS-1:0] at_max;
  logic              accept, tgt_sat, trig_sat, discard, beat, last_beat;

  // Only the index field of the sample matters; the rest is deliberately ignored.
  logic unused_data;
  assign unused_data = ^data_in;

  assign idx       = data_in[IDX_LSB +: IDX_W];
  assign accept    = in_valid && in_ready;
  assign tgt_sat   = at_max[idx];
  assign trig_sat  = accept && tgt_sat && auto_dump_en;
  assign discard   = accept && tgt_sat && !auto_dump_en;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && (ptr_q == LastBin);

  // Per-bin counters, each sized to its own width.
  for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
    localparam int unsigned W = (i < WIDE_BINS) ? WIDE_W : NARROW_W;
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && !tgt_sat && (idx == IDX_W'(i))) cnt_d = cnt_q + W'(1);
      if (beat && (ptr_q == IDX_W'(i)))             cnt_d = '0;
      // Pending sample lands on the closing edge, overriding the clear of the last bin.
      if (last_beat && pend_q && (pend_idx_q == IDX_W'(i))) cnt_d = W'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign at_max[i] = &cnt_q;
    assign rd[i]     = WIDE_W'(cnt_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trig_sat || dump_req) state_d = StDump;
      StDump:  if (last_beat)            state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDump);
    out_bin   = ptr_q;
    out_data  = rd[ptr_q];
    out_last  = out_valid && (ptr_q == LastBin);
    sat_flag  = sat_q;
  end

  // Pointer, pending sample and sticky flag
  always_comb begin
    // Pointer wraps to 0 naturally after the last bin.
    ptr_d      = beat ? ptr_q + IDX_W'(1) : ptr_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    sat_d      = sat_q;
    if (trig_sat) begin
      pend_d     = 1'b1;
      pend_idx_d = idx;
    end else if (last_beat) begin
      pend_d = 1'b0;
    end
    if (discard)        sat_d = 1'b1;
    else if (last_beat) sat_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_histogram_stream.sv
module tb_histogram_stream;
  localparam int NB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, in_valid, in_ready, dump_req, auto_dump_en;
  logic        out_valid, out_ready, out_last, sat_flag;
  logic [15:0] data_in;
  logic [7:0]  out_data;
  logic [5:0]  out_bin;

  // Alternate-parameter instance
  logic        a_rst_n, a_in_valid, a_in_ready, a_dump_req, a_auto;
  logic        a_out_valid, a_out_ready, a_out_last, a_sat_flag;
  logic [15:0] a_data;
  logic [5:0]  a_out_data;
  logic [3:0]  a_out_bin;

  histogram_stream dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .dump_req(dump_req), .auto_dump_en(auto_dump_en), .out_data(out_data), .out_bin(out_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .sat_flag(sat_flag)
  );

  histogram_stream #(.IDX_W(4), .WIDE_BINS(16), .WIDE_W(6)) dut_alt (
    .clk(clk), .rst_n(a_rst_n), .data_in(a_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .dump_req(a_dump_req), .auto_dump_en(a_auto),
    .out_data(a_out_data), .out_bin(a_out_bin), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .sat_flag(a_sat_flag)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int bin; int data;} beat_t;
  beat_t sb[$];
  int    model[NB];
  bit    exp_sat;

  function automatic int bmax(int i);
    return (i < 10) ? 255 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Snapshot the model into the scoreboard and clear it, applying a pending sample.
  task automatic push_dump(input bit pend, input int pidx);
    for (int i = 0; i < NB; i++) begin
      sb.push_back('{i, model[i]});
      model[i] = 0;
    end
    if (pend) model[pidx] = 1;
  endtask

  task automatic model_sample(input int idx);
    if (model[idx] < bmax(idx)) model[idx]++;
    else if (auto_dump_en) push_dump(1'b1, idx);
    else exp_sat = 1'b1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic sample(input int idx);
    check("in_ready_idle", in_ready, 1);
    data_in  = 16'(idx);
    in_valid = 1'b1;
    model_sample(idx);
    @(negedge clk);
    in_valid = 1'b0;
    check("sat_flag", sat_flag, exp_sat);
  endtask

  task automatic req_dump();
    dump_req = 1'b1;
    push_dump(1'b0, 0);
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  task automatic req_dump_with_sample(input int idx);
    dump_req = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'(idx);
    model_sample(idx);
    push_dump(1'b0, 0);
    @(negedge clk);
    dump_req = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int nbeats, input bit bp, input int budget);
    int got = 0;
    int cyc = 0;
    bit rdy;
    check("first_beat_valid", out_valid, 1);
    while (got < nbeats && cyc < budget) begin
      rdy       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (sb.size() > 0) begin
          check("out_bin", out_bin, sb[0].bin);
          check("out_data", out_data, sb[0].data);
          check("out_last", out_last, sb[0].bin == NB - 1);
          check("in_ready_dump", in_ready, 0);
          if (rdy) begin
            void'(sb.pop_front());
            got++;
          end
        end else begin
          check("sb_nonempty", sb.size(), 1);
          got++;
        end
      end else begin
        check("out_valid_dump", out_valid, 1);
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("dump_beats", got, nbeats);
    if (!bp) check("dump_cycles", cyc, nbeats);
    if (nbeats == NB) begin
      exp_sat = 1'b0;
      check("idle_after_in_ready", in_ready, 1);
      check("idle_after_out_valid", out_valid, 0);
      check("sat_after_dump", sat_flag, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) model[i] = 0;
    exp_sat      = 1'b0;
    rst_n        = 1'b0;
    a_rst_n      = 1'b0;
    in_valid     = 1'b1;
    dump_req     = 1'b1;
    data_in      = 16'd5;
    auto_dump_en = 1'b0;
    out_ready    = 1'b0;
    a_in_valid   = 1'b0;
    a_dump_req   = 1'b0;
    a_auto       = 1'b0;
    a_out_ready  = 1'b0;
    a_data       = '0;

    // Reset with activity on the inputs
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    a_rst_n  = 1'b1;
    in_valid = 1'b0;
    dump_req = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_out_bin", out_bin, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    req_dump();
    collect(NB, 1'b0, 1000);

    // Basic counting, then a second dump that must be empty
    repeat (5) sample(3);
    repeat (2) sample(20);
    req_dump();
    collect(NB, 1'b0, 1000);
    req_dump();
    collect(NB, 1'b0, 1000);

    // Auto-dump on a wide bin with a pending sample
    auto_dump_en = 1'b1;
    repeat (256) sample(0);
    collect(NB, 1'b0, 1000);
    req_dump();
    collect(NB, 1'b0, 1000);

    // Narrow saturation without dump
    auto_dump_en = 1'b0;
    repeat (20) sample(40);
    req_dump();
    collect(NB, 1'b0, 1000);

    // Sample accepted in the same cycle as dump_req is included
    req_dump_with_sample(7);
    collect(NB, 1'b0, 1000);

    // Backpressure
    sample(3);
    sample(12);
    sample(12);
    req_dump();
    collect(NB, 1'b1, 1000);

    // Reset mid-dump
    repeat (3) sample(5);
    req_dump();
    collect(11, 1'b0, 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < NB; i++) model[i] = 0;
    exp_sat = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    req_dump();
    collect(NB, 1'b0, 1000);

    // Alternate parameters: 64th sample to bin 15 saturates the 6-bit counter
    a_auto      = 1'b1;
    a_out_ready = 1'b1;
    a_data      = 16'd15;
    for (int c = 0; c < 80; c++) begin
      if (c < 64) begin
        check("a_in_ready", a_in_ready, 1);
        check("a_out_valid_idle", a_out_valid, 0);
      end else begin
        check("a_in_ready_dump", a_in_ready, 0);
        check("a_out_valid", a_out_valid, 1);
        check("a_out_bin", a_out_bin, c - 64);
        check("a_out_data", a_out_data, (c == 79) ? 63 : 0);
        check("a_out_last", a_out_last, c == 79);
      end
      a_in_valid = (c < 70);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    check("a_in_ready_after", a_in_ready, 1);
    a_dump_req = 1'b1;
    @(negedge clk);
    a_dump_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("a_dump2_bin", a_out_bin, k);
      check("a_dump2_data", a_out_data, (k == 15) ? 1 : 0);
      @(negedge clk);
    end
    check("a_in_ready_end", a_in_ready, 1);
    check("a_sat_flag", a_sat_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_stream.md
# histogram_stream

Parametrised successor to the team's fixed 64-bin histogrammer. Bins a streaming sample index into a configurable mix of wide and narrow saturating counters. Dumps all bins over a ready/valid output stream with backpressure, clearing each bin as it is read. A dump starts on counter saturation (optional) or on external request. Sits between the sample front-end and the readout serialiser.

## Interface
Parameters:
- DATA_W, 16, input sample width
- IDX_LSB, 0, LSB of the bin-index field in data_in
- IDX_W, 6, index width; NUM_BINS = 2**IDX_W
- WIDE_BINS, 10, bins 0..WIDE_BINS-1 are WIDE_W bits; the rest are NARROW_W bits (1 ≤ WIDE_BINS ≤ NUM_BINS)
- WIDE_W, 8, wide counter width and out_data width
- NARROW_W, 4, narrow counter width (NARROW_W ≤ WIDE_W)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- data_in  in  DATA_W  sample; bin = data_in[IDX_LSB+IDX_W-1:IDX_LSB]
- in_valid  in  1  sample present
- in_ready  out  1  block accepts samples; high exactly in IDLE
- dump_req  in  1  request a full dump (single-cycle pulse sufficient)
- auto_dump_en  in  1  1: hitting a saturated bin triggers a dump; 0: saturate silently
- out_data  out  WIDE_W  count of bin out_bin, narrow bins zero-extended
- out_bin  out  IDX_W  index of the bin currently presented
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_last  out  1  high with the beat for bin NUM_BINS-1
- sat_flag  out  1  sticky; set when a sample is discarded at saturation (auto_dump_en=0); cleared by reset or at dump completion

## Operation
- Two states: IDLE, DUMP. Accept = in_valid && in_ready.
- IDLE, accept, target bin below max: bin += 1.
- IDLE, accept, target bin at max (all ones), auto_dump_en=1: bin unchanged; index stored as pending; go to DUMP.
- IDLE, accept, target bin at max, auto_dump_en=0: sample discarded, sat_flag ← 1, stay IDLE.
- IDLE, dump_req=1: go to DUMP with no pending sample. If a sample is accepted in the same cycle, it is counted (or triggers a pending dump per the rules above) and is included in the dump.
- DUMP: pointer starts at 0. out_valid=1 and out_bin=pointer. out_data = current value of bin[pointer]. On out_valid && out_ready: bin[pointer] ← 0 and pointer += 1.
- Beat for pointer NUM_BINS-1 accepted: go to IDLE and clear sat_flag. If a sample is pending, its bin ← 1 on the same edge; this also holds when the pending bin is NUM_BINS-1.
- dump_req and in_valid are ignored in DUMP. Samples are never counted in DUMP.
- Counters never wrap.

## Timing
- Reset (rst_n low at an edge): all bins 0, state IDLE, pointer 0, pending cleared, sat_flag 0. From the next cycle: out_valid 0, out_last 0, out_bin 0, in_ready 1. out_data shows bin[0], i.e. 0.
- Reset mid-dump aborts the dump. The pending sample is lost and all counts are zeroed.
- Trigger (saturating accept or dump_req) in cycle T: in_ready low from T+1, first beat (bin 0) valid in T+1.
- Throughput is one beat per cycle with out_ready held high. Minimum dump is NUM_BINS cycles, last beat at T+NUM_BINS.
- Last beat accepted in cycle L: in_ready high in L+1. The pending count is visible from L+1.
- While out_valid && !out_ready, out_bin, out_data and out_last are held stable.
- out_last == out_valid && (out_bin == NUM_BINS-1).

## Test plan
- Reset: drive samples and dump_req with rst_n low for 3 cycles, then release → out_valid=0, in_ready=1, sat_flag=0; a subsequent dump_req yields 64 beats, all 0.
- Basic count (defaults): 5 samples with index 3, 2 with index 20, then dump_req, out_ready=1 → 64 consecutive beats; bin 3 = 5, bin 20 = 2, others 0; out_last only on out_bin=63. A second dump returns all 0.
- Auto-dump on wide bin: auto_dump_en=1, 256 samples with index 0 → 256th accept triggers dump; beat 0 = 255. The next dump shows bin 0 = 1.
- Narrow saturation without dump: auto_dump_en=0, 20 samples with index 40 → sat_flag=1 after the 16th; in_ready stays 1. dump_req shows bin 40 = 15, and sat_flag = 0 after the dump.
- Backpressure: during a dump, toggle out_ready pseudo-randomly → held beats are stable, exactly 64 beats with out_bin 0..63 in order, in_ready low throughout.
- Reset mid-dump plus alternate parameters (IDX_W=4, WIDE_BINS=16, WIDE_W=6): reset after beat 10 → out_valid=0 next cycle, and a following dump is all zeros. Separately, 70 samples to bin 15 with auto_dump_en=1 → the 64th accept triggers a dump; last beat = 63; bin 15 = 1 afterwards.
